// File: rtl/branch_pred_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_pred_unit
// Description : 4-way set-associative branch target buffer with 2-bit
//               saturating direction counters and per-set tree-PLRU
//               replacement. Zero-cycle lookup, single update port.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_pred_unit #(
    parameter int ADDR_WIDTH = 64,
    parameter int SET_COUNT  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_stall_exec,
    input  logic                  i_branch_exec,
    input  logic                  i_branch_taken_exec,
    input  logic [ADDR_WIDTH-1:0] i_pc_exec,
    input  logic [ADDR_WIDTH-1:0] i_pc_target_exec,
    input  logic [1:0]            i_btb_way_exec,
    output logic                  o_branch_pred_taken,
    output logic [ADDR_WIDTH-1:0] o_pc_target_pred,
    output logic [1:0]            o_btb_way
);

    localparam int         INDEX_W     = $clog2(SET_COUNT);
    localparam int         TAG_W       = ADDR_WIDTH - INDEX_W - 2;
    localparam logic [1:0] C_CTR_RESET = 2'b01;
    localparam logic [1:0] C_CTR_ALLOC = 2'b10;
    localparam logic [1:0] C_CTR_MAX   = 2'b11;

    // Storage: per-set valid vector and PLRU bits {b2,b1,b0}; per-way tag/target/counter
    logic [3:0]            valid_q  [SET_COUNT];
    logic [3:0]            valid_d  [SET_COUNT];
    logic [TAG_W-1:0]      tag_q    [SET_COUNT][4];
    logic [TAG_W-1:0]      tag_d    [SET_COUNT][4];
    logic [ADDR_WIDTH-1:0] target_q [SET_COUNT][4];
    logic [ADDR_WIDTH-1:0] target_d [SET_COUNT][4];
    logic [1:0]            ctr_q    [SET_COUNT][4];
    logic [1:0]            ctr_d    [SET_COUNT][4];
    logic [2:0]            plru_q   [SET_COUNT];
    logic [2:0]            plru_d   [SET_COUNT];

    logic [INDEX_W-1:0]    w_lk_idx;
    logic [TAG_W-1:0]      w_lk_tag;
    logic                  w_hit;
    logic [1:0]            w_hit_way;
    logic                  w_inv_found;
    logic [1:0]            w_inv_way;
    logic [1:0]            w_victim;

    logic [INDEX_W-1:0]    w_up_idx;
    logic [TAG_W-1:0]      w_up_tag;
    logic                  w_up_hit;
    logic                  w_touch;

    // The two low PC bits of the resolved instruction never select an entry.
    logic                  unused_exec_lsbs;
    assign unused_exec_lsbs = ^i_pc_exec[1:0];

    assign w_lk_idx = i_pc[INDEX_W+1:2];
    assign w_lk_tag = i_pc[ADDR_WIDTH-1:INDEX_W+2];
    assign w_up_idx = i_pc_exec[INDEX_W+1:2];
    assign w_up_tag = i_pc_exec[ADDR_WIDTH-1:INDEX_W+2];
    // Update port trusts the way reported at lookup time; no other way is searched.
    assign w_up_hit = valid_q[w_up_idx][i_btb_way_exec] &&
                      (tag_q[w_up_idx][i_btb_way_exec] == w_up_tag);

    // Lookup: search all four ways of the fetch set, pick hit way or fill way
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = 2'd0;
        w_inv_found = 1'b0;
        w_inv_way   = 2'd0;
        // Descending scan so the lowest-numbered match wins.
        for (int w = 3; w >= 0; w--) begin
            if (valid_q[w_lk_idx][w] && (tag_q[w_lk_idx][w] == w_lk_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = 2'(w);
            end
            if (!valid_q[w_lk_idx][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = 2'(w);
            end
        end
        if (!plru_q[w_lk_idx][0]) begin
            w_victim = plru_q[w_lk_idx][1] ? 2'd1 : 2'd0;
        end else begin
            w_victim = plru_q[w_lk_idx][2] ? 2'd3 : 2'd2;
        end
        o_branch_pred_taken = w_hit && ctr_q[w_lk_idx][w_hit_way][1];
        o_pc_target_pred    = o_branch_pred_taken ? target_q[w_lk_idx][w_hit_way]
                                                  : i_pc + ADDR_WIDTH'(4);
        o_btb_way           = w_hit ? w_hit_way : (w_inv_found ? w_inv_way : w_victim);
    end

    // Next state: train counter/target on hit, allocate on taken miss, touch PLRU
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        plru_d   = plru_q;
        w_touch  = 1'b0;
        if (i_branch_exec && !i_stall_exec) begin
            if (w_up_hit) begin
                w_touch = 1'b1;
                if (i_branch_taken_exec) begin
                    target_d[w_up_idx][i_btb_way_exec] = i_pc_target_exec;
                    if (ctr_q[w_up_idx][i_btb_way_exec] != C_CTR_MAX) begin
                        ctr_d[w_up_idx][i_btb_way_exec] = ctr_q[w_up_idx][i_btb_way_exec] + 2'd1;
                    end
                end else if (ctr_q[w_up_idx][i_btb_way_exec] != 2'd0) begin
                    ctr_d[w_up_idx][i_btb_way_exec] = ctr_q[w_up_idx][i_btb_way_exec] - 2'd1;
                end
            end else if (i_branch_taken_exec) begin
                w_touch = 1'b1;
                valid_d[w_up_idx][i_btb_way_exec]  = 1'b1;
                tag_d[w_up_idx][i_btb_way_exec]    = w_up_tag;
                target_d[w_up_idx][i_btb_way_exec] = i_pc_target_exec;
                ctr_d[w_up_idx][i_btb_way_exec]    = C_CTR_ALLOC;
            end
        end
        if (w_touch) begin
            case (i_btb_way_exec)
                2'd0:    begin plru_d[w_up_idx][0] = 1'b1; plru_d[w_up_idx][1] = 1'b1; end
                2'd1:    begin plru_d[w_up_idx][0] = 1'b1; plru_d[w_up_idx][1] = 1'b0; end
                2'd2:    begin plru_d[w_up_idx][0] = 1'b0; plru_d[w_up_idx][2] = 1'b1; end
                default: begin plru_d[w_up_idx][0] = 1'b0; plru_d[w_up_idx][2] = 1'b0; end
            endcase
        end
    end

    // State register; reset clears valids, weakly-not-taken counters, PLRU zero
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            for (int s = 0; s < SET_COUNT; s++) begin
                valid_q[s] <= 4'd0;
                plru_q[s]  <= 3'd0;
                for (int w = 0; w < 4; w++) begin
                    tag_q[s][w]    <= '0;
                    target_q[s][w] <= '0;
                    ctr_q[s][w]    <= C_CTR_RESET;
                end
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
            plru_q   <= plru_d;
        end
    end

endmodule
`default_nettype wire
